// File: rtl/cla_seq_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead slice stepped per nibble.
// Optional subtract mode (sub input, ovf output) under `CLA_SEQ_SUB_EN.
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c3,
    output logic       o_co
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_co   = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s  = w_p ^ w_c;
    assign o_c3 = w_c[3];
endmodule

module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_seq_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             w_inv;
    logic             w_last;
    logic             w_accept;
    logic [3:0]       w_s;
    logic             w_c3;
    logic             w_co;

`ifdef CLA_SEQ_SUB_EN
    logic r_sub;
    logic r_ovf;
    assign w_inv = r_sub;
    assign ovf   = r_ovf;
`else
    logic w_unused_c3;
    assign w_inv       = 1'b0;
    assign w_unused_c3 = w_c3;
`endif

    assign w_last   = (r_cnt == CW'(NIB - 1));
    assign w_accept = (r_state == S_IDLE) && in_valid;

    cla4_slice u_slice (
        .i_a  (r_a[3:0]),
        .i_b  (r_b[3:0] ^ {4{w_inv}}),
        .i_c  (r_c),
        .o_s  (w_s),
        .o_c3 (w_c3),
        .o_co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid)  w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    // Operands shift down so the slice always sees nibble 0 of r_a/r_b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            r_sub  <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
`ifdef CLA_SEQ_SUB_EN
            r_sub <= sub;
            r_c   <= sub | cin;
`else
            r_c   <= cin;
`endif
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 4;
            r_b   <= r_b >> 4;
            r_sum[{r_cnt, 2'b00} +: 4] <= w_s;
            r_c   <= w_co;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_co;
`ifdef CLA_SEQ_SUB_EN
                r_ovf  <= w_c3 ^ w_co;
`endif
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Randomized bench for cla_seq_ctrl against an integer-arithmetic model.
// Subtract cases run only when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;
`ifdef CLA_SEQ_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SEQ_SUB_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cla_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jam();
        in_valid  = 1'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        sub       = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input int hold);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic [W-1:0] held;
        logic         eovf;
        int           t;
        bb   = ts ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bb} + (ts ? (W+1)'(1) : (W+1)'(tc));
        eovf = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
        in_valid = 1'b1;
        a = ta; b = tb; cin = tc; sub = ts;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        check("in_ready_before_accept", in_ready, 1);
        step();
        check("busy_in_run", busy, 1);
        check("in_ready_in_run", in_ready, 0);
        for (int i = 1; i <= NIB; i++) begin
            jam();
            out_ready = 1'($urandom);
            step();
            check("latency_out_valid", out_valid, 32'(i == NIB));
        end
        out_ready = 1'b0;
        held = sum;
        for (int h = 0; h < hold; h++) begin
            jam();
            step();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_stable", sum, held);
        end
        check("sum", sum, full[W-1:0]);
        check("cout", cout, full[W]);
`ifdef CLA_SEQ_SUB_EN
        check("ovf", ovf, eovf);
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        check("out_valid_drop", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'hBEEF, 16'h1111, 1'b0, 1'b0, 5);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);

        in_valid = 1'b1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrun_in_ready", in_ready, 1);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_sum", sum, 0);
        check("midrun_cout", cout, 0);
        check("midrun_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid", out_valid, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        if (HAS_SUB) begin
            run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
            run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 2);
        end

        for (int k = 0; k < 40; k++)
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom) & HAS_SUB, int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
